// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit: operands and decode fields in,
// registered result out, each direction with its own valid/ready handshake.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       ALUOp;
    logic [6:0]       Funct7;
    logic [2:0]       Funct3;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Illegal;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output ALUOp, Funct7, Funct3, SrcA, SrcB, in_valid, out_ready,
        input  in_ready, Result, Zero, Illegal, out_valid
    );

    modport slave (
        input  ALUOp, Funct7, Funct3, SrcA, SrcB, in_valid, out_ready,
        output in_ready, Result, Zero, Illegal, out_valid
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue ALU: simple ops finish in one cycle, unsigned MUL/MULHU/DIVU/REMU
// iterate one bit per cycle through a shared 2*WIDTH accumulator.
module alu_exec_unit #(
    parameter int WIDTH     = 32,
    parameter int MULDIV_EN = 1
) (
    input  logic          clk,
    input  logic          reset,
    alu_exec_unit_if.slave bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    typedef enum logic [1:0] {MD_MUL, MD_MULHU, MD_DIVU, MD_REMU} md_op_t;

    state_t             state_reg, state_next;
    md_op_t             md_op_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg;
    logic               illegal_reg;

    logic [WIDTH-1:0]   a, b;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH-1:0]   simple_res;
    logic               dec_illegal;
    logic               dec_muldiv;
    md_op_t             dec_md_op;
    logic               taken;

    assign a     = bus.SrcA;
    assign b     = bus.SrcB;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        simple_res  = '0;
        dec_illegal = 1'b0;
        dec_muldiv  = 1'b0;
        dec_md_op   = MD_MUL;
        taken       = 1'b0;
        case (bus.ALUOp)
            2'b00: simple_res = a + b;
            2'b01: begin
                case (bus.Funct3)
                    3'b000:  taken = (a == b);
                    3'b001:  taken = (a != b);
                    3'b100:  taken = ($signed(a) < $signed(b));
                    3'b101:  taken = ($signed(a) >= $signed(b));
                    3'b110:  taken = (a < b);
                    3'b111:  taken = (a >= b);
                    default: dec_illegal = 1'b1;
                endcase
                simple_res = {{(WIDTH-1){1'b0}}, taken};
            end
            2'b10: begin
                case (bus.Funct7)
                    7'b0000000: begin
                        case (bus.Funct3)
                            3'b000:  simple_res = a + b;
                            3'b001:  simple_res = a << shamt;
                            3'b010:  simple_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                            3'b011:  simple_res = {{(WIDTH-1){1'b0}}, a < b};
                            3'b100:  simple_res = a ^ b;
                            3'b101:  simple_res = a >> shamt;
                            3'b110:  simple_res = a | b;
                            default: simple_res = a & b;
                        endcase
                    end
                    7'b0100000: begin
                        case (bus.Funct3)
                            3'b000:  simple_res = a - b;
                            3'b101:  simple_res = $unsigned($signed(a) >>> shamt);
                            default: dec_illegal = 1'b1;
                        endcase
                    end
                    7'b0000001: begin
                        if (MULDIV_EN != 0) begin
                            dec_muldiv = 1'b1;
                            case (bus.Funct3)
                                3'b000:  dec_md_op = MD_MUL;
                                3'b011:  dec_md_op = MD_MULHU;
                                3'b101:  dec_md_op = MD_DIVU;
                                3'b111:  dec_md_op = MD_REMU;
                                default: begin
                                    dec_muldiv  = 1'b0;
                                    dec_illegal = 1'b1;
                                end
                            endcase
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: simple_res = b;
        endcase
        if (dec_illegal) begin
            simple_res = '0;
        end
    end

    // Multiply step: conditionally add the multiplicand into the upper half, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? opnd_reg : '0)};
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide step: upper half is the partial remainder, lower half collects quotient bits.
    // A zero divisor always subtracts cleanly, giving all-ones quotient and remainder = dividend.
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    assign div_rem_sh = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff   = div_rem_sh - {1'b0, opnd_reg};
    assign div_ok     = ~div_diff[WIDTH];
    assign div_next   = {(div_ok ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                         acc_reg[WIDTH-2:0], div_ok};

    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   md_res;
    always_comb begin
        step_next = div_next;
        md_res    = '0;
        if (md_op_reg == MD_MUL || md_op_reg == MD_MULHU) begin
            step_next = mul_next;
        end
        case (md_op_reg)
            MD_MUL:   md_res = step_next[WIDTH-1:0];
            MD_MULHU: md_res = step_next[2*WIDTH-1:WIDTH];
            MD_DIVU:  md_res = step_next[WIDTH-1:0];
            default:  md_res = step_next[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = dec_muldiv ? ITER : DONE;
                end
            end
            ITER: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_op_reg   <= MD_MUL;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (dec_muldiv) begin
                            md_op_reg <= dec_md_op;
                            cnt_reg   <= CNT_W'(WIDTH);
                            acc_reg   <= {{WIDTH{1'b0}}, a};
                            opnd_reg  <= b;
                        end else begin
                            result_reg  <= simple_res;
                            zero_reg    <= (simple_res == '0);
                            illegal_reg <= dec_illegal;
                        end
                    end
                end
                ITER: begin
                    acc_reg <= step_next;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        result_reg  <= md_res;
                        zero_reg    <= (md_res == '0);
                        illegal_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.Result    = result_reg;
    assign bus.Zero      = zero_reg;
    assign bus.Illegal   = illegal_reg;
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8..64, even.
REQ-002 Parameter MULDIV_EN, default 1, 1 enables RV32M subset MUL/MULHU/DIVU/REMU, 0 treats them as illegal.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ALUOp  input  2  00 LW/SW/AUIPC add; 01 branch compare; 10 R/I-type; 11 JAL/LUI pass-through.
REQ-006 Funct7  input  7  instruction bits 31:25.
REQ-007 Funct3  input  3  instruction bits 14:12.
REQ-008 SrcA, SrcB  input  WIDTH each  operands.
REQ-009 in_valid  input  1  request present; in_ready  output  1  unit can accept.
REQ-010 Result  output  WIDTH  registered result; Zero  output  1  Result==0; Illegal  output  1  unsupported encoding.
REQ-011 out_valid  output  1  Result/Zero/Illegal valid; out_ready  input  1  consumer accepts.

Function
REQ-012 Request accepted on a clk edge where in_valid && in_ready; inputs sampled only then.
REQ-013 FSM states IDLE, ITER, DONE; in_ready = (state==IDLE).
REQ-014 IDLE + accepted simple op -> DONE, Result registered; latency 1 cycle (out_valid the cycle after acceptance).
REQ-015 IDLE + accepted MUL/MULHU/DIVU/REMU -> ITER, counter loaded with WIDTH; one bit per cycle; counter==1 -> DONE; latency WIDTH+1 cycles.
REQ-016 DONE holds Result, Zero, Illegal, out_valid=1 stable until out_ready; out_valid && out_ready -> IDLE; no new acceptance in the same cycle.
REQ-017 ALUOp 00: Result = SrcA+SrcB, modulo 2^WIDTH.
REQ-018 ALUOp 01: Funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; Result = {WIDTH-1 zeros, taken}; Funct3 010/011 illegal.
REQ-019 ALUOp 10, Funct7 0000000: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-020 ALUOp 10, Funct7 0100000: 000 SUB, 101 SRA; other Funct3 illegal.
REQ-021 ALUOp 10, Funct7 0000001 (MULDIV_EN=1): 000 MUL low WIDTH bits, 011 MULHU high WIDTH bits unsigned, 101 DIVU, 111 REMU; other Funct3 illegal.
REQ-022 Shift amount = SrcB[$clog2(WIDTH)-1:0]; upper SrcB bits ignored.
REQ-023 ALUOp 11: Result = SrcB.
REQ-024 Multiply: iterative shift-add, 2*WIDTH-bit product register, unsigned.
REQ-025 Divide: iterative restoring, unsigned; divisor 0 -> DIVU result all ones, REMU result = SrcA, still WIDTH+1 latency.
REQ-026 Illegal encoding: Result = 0, Zero = 1, Illegal = 1, latency 1 cycle; never enters ITER.
REQ-027 Zero computed from final registered Result, valid with out_valid.
REQ-028 in_valid while not in IDLE is ignored (not queued); requester must hold it.

Reset
REQ-029 reset=1 at an edge forces IDLE regardless of state, including mid-ITER or DONE; in-flight op discarded.
REQ-030 Reset values: out_valid 0, Result 0, Zero 0, Illegal 0, counter 0, product/quotient registers 0; in_ready 1 the cycle after reset deasserts.
REQ-031 reset has priority over a simultaneous in_valid or out_ready.

Verification
REQ-032 WIDTH=32, ALUOp 10, F7 0100000, F3 000, A=5, B=7 -> out_valid next cycle, Result 0xFFFFFFFE, Zero 0, Illegal 0.
REQ-033 ALUOp 01, F3 100, A=0xFFFFFFFF, B=1 -> Result 1; same with F3 110 -> Result 0.
REQ-034 MUL A=0x10000, B=0x10000 -> out_valid exactly 33 cycles after acceptance, Result 0; MULHU same operands -> Result 1; in_ready 0 throughout.
REQ-035 DIVU A=100, B=0 -> Result 0xFFFFFFFF; REMU A=100, B=7 -> Result 2 after 33 cycles.
REQ-036 out_ready held 0 for 5 cycles in DONE -> Result stable, in_ready 0; then out_ready 1 -> IDLE next cycle.
REQ-037 reset asserted at ITER cycle 10 -> next cycle out_valid 0, in_ready 1 after deassert; subsequent ADD 3+4 returns 7.
